// File: rtl/shift_register_ctrl_pkg.sv
// Shared encodings for the shift register controller: mode select, FSM states,
// shift-unit operations and direction constants.
package shift_register_ctrl_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_SHIFT  = 2'b01,
        OP_ROTATE = 2'b10
    } op_t;

endpackage

// File: rtl/shift_register_ctrl_shift.sv
// Combinational next-value logic shared by the mode path and the transfer engine.
module shift_unit
    import shift_register_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             sin,
    input  op_t              op,
    input  logic             dir,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            OP_SHIFT:  q_next = (dir == DIR_LEFT) ? {q[WIDTH-2:0], sin}
                                                  : {sin, q[WIDTH-1:1]};
            OP_ROTATE: q_next = (dir == DIR_LEFT) ? {q[WIDTH-2:0], q[WIDTH-1]}
                                                  : {q[0], q[WIDTH-1:1]};
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/shift_register_ctrl.sv
// WIDTH-bit register bank with load/shift/rotate/clear modes and an automatic
// serial-transfer engine that shifts out all WIDTH bits with busy/done status.
//
// state | meaning
// IDLE  | mode commands applied; start launches a transfer
// SHIFT | one bit shifted per enabled edge until cnt reaches 0
module shift_register_ctrl
    import shift_register_ctrl_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pdata_in,
    input  logic             sin,
    input  logic             start,
    input  logic             shift_dir,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_r, state_nxt;
    logic [CW-1:0]    cnt_r, cnt_nxt;
    logic [WIDTH-1:0] q_r, q_nxt, su_q;
    logic             dir_r, dir_nxt;
    logic             done_r, done_nxt;
    op_t              su_op;
    logic             su_dir;

    shift_unit #(.WIDTH(WIDTH)) u_shift (
        .q      (q_r),
        .sin    (sin),
        .op     (su_op),
        .dir    (su_dir),
        .q_next (su_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            q_r     <= RESET_VALUE;
            dir_r   <= DIR_LEFT;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            q_r     <= q_nxt;
            dir_r   <= dir_nxt;
            done_r  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        if (en) begin
            case (state_r)
                IDLE:    if (start) state_nxt = SHIFT;
                SHIFT:   if (cnt_r == CW'(1)) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath next values; the shift unit is steered by whichever path is active.
    always_comb begin
        q_nxt    = q_r;
        cnt_nxt  = cnt_r;
        dir_nxt  = dir_r;
        done_nxt = 1'b0;
        su_op    = OP_HOLD;
        su_dir   = dir_r;
        if (en) begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cnt_nxt = CW'(WIDTH);
                        dir_nxt = shift_dir;
                    end else begin
                        case (mode)
                            MODE_LOAD: q_nxt = pdata_in;
                            MODE_SHL: begin
                                su_op = OP_SHIFT;  su_dir = DIR_LEFT;
                                q_nxt = su_q;      dir_nxt = DIR_LEFT;
                            end
                            MODE_SHR: begin
                                su_op = OP_SHIFT;  su_dir = DIR_RIGHT;
                                q_nxt = su_q;      dir_nxt = DIR_RIGHT;
                            end
                            MODE_ROL: begin
                                su_op = OP_ROTATE; su_dir = DIR_LEFT;
                                q_nxt = su_q;      dir_nxt = DIR_LEFT;
                            end
                            MODE_ROR: begin
                                su_op = OP_ROTATE; su_dir = DIR_RIGHT;
                                q_nxt = su_q;      dir_nxt = DIR_RIGHT;
                            end
                            MODE_CLR: q_nxt = RESET_VALUE;
                            default:  q_nxt = q_r;
                        endcase
                    end
                end
                SHIFT: begin
                    su_op = OP_SHIFT;
                    q_nxt = su_q;
                    if (cnt_r != '0) cnt_nxt = cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) done_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state_r == SHIFT);
        sout = (dir_r == DIR_LEFT) ? q_r[WIDTH-1] : q_r[0];
    end

    assign q    = q_r;
    assign done = done_r;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Directed bench for shift_register_ctrl (WIDTH=8, RESET_VALUE=0): modes,
// serial transfer, stall, reset abort and back-to-back transfers.
module tb_shift_register_ctrl;

    logic       clk = 1'b0;
    logic       reset, en, sin, start, shift_dir;
    logic [2:0] mode;
    logic [7:0] pdata_in, q;
    logic       sout, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    shift_register_ctrl #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .pdata_in(pdata_in),
        .sin(sin), .start(start), .shift_dir(shift_dir),
        .q(q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_a5();
        en = 1'b1; start = 1'b0; mode = 3'b001; pdata_in = 8'hA5;
        step();
        mode = 3'b000;
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] v1d;
        a5  = 8'hA5;
        v1d = 8'h1D;
        reset = 1'b1; en = 1'b0; sin = 1'b0; start = 1'b0; shift_dir = 1'b0;
        mode = 3'b000; pdata_in = 8'h00;
        step();
        chk("reset_q", q, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        reset = 1'b0;

        load_a5();
        chk("load_q", q, 8'hA5);
        step();
        chk("hold_q", q, 8'hA5);
        en = 1'b0; mode = 3'b110;
        step();
        chk("en0_clear_ignored", q, 8'hA5);

        load_a5(); mode = 3'b010; sin = 1'b1; step();
        chk("shl_q", q, 8'h4B);
        chk("shl_sout", sout, 1'b0);
        load_a5(); mode = 3'b011; sin = 1'b0; step();
        chk("shr_q", q, 8'h52);
        chk("shr_sout", sout, 1'b0);
        load_a5(); mode = 3'b100; step();
        chk("rol_q", q, 8'h4B);
        load_a5(); mode = 3'b101; step();
        chk("ror_q", q, 8'hD2);
        chk("ror_sout", sout, 1'b0);
        mode = 3'b111; step();
        chk("reserved_hold", q, 8'hD2);
        mode = 3'b110; step();
        chk("clr_q", q, 8'h00);

        // Plain MSB-first transfer of 0xA5.
        load_a5(); start = 1'b1; shift_dir = 1'b0; sin = 1'b0;
        step();
        start = 1'b0;
        chk("xfer_start_q", q, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            chk("xfer_sout", sout, a5[7-i]);
            chk("xfer_busy", busy, 1'b1);
            chk("xfer_done_low", done, 1'b0);
            step();
        end
        chk("xfer_end_q", q, 8'h00);
        chk("xfer_end_busy", busy, 1'b0);
        chk("xfer_done", done, 1'b1);
        step();
        chk("xfer_done_pulse", done, 1'b0);

        // Stall for 3 cycles with start/load pulsed; both must be ignored.
        load_a5(); start = 1'b1; shift_dir = 1'b0; sin = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stall_sout_pre", sout, a5[7-i]);
            step();
        end
        chk("stall_q_mid", q, 8'h94);
        en = 1'b0; start = 1'b1; mode = 3'b001; pdata_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_q_held", q, 8'h94);
            chk("stall_busy", busy, 1'b1);
            chk("stall_done_low", done, 1'b0);
        end
        en = 1'b1;
        for (int i = 2; i < 8; i++) begin
            chk("stall_sout_post", sout, a5[7-i]);
            chk("stall_done_low2", done, 1'b0);
            if (i == 6) begin start = 1'b0; mode = 3'b000; end
            step();
        end
        chk("stall_end_q", q, 8'h00);
        chk("stall_done", done, 1'b1);
        step();

        // Reset four shifts into a transfer.
        load_a5(); start = 1'b1; shift_dir = 1'b0; sin = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("abort_q_mid", q, 8'h50);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_q", q, 8'h00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_done", done, 1'b0);
            chk("abort_idle", busy, 1'b0);
        end

        // MSB-first transfer fills q with 0x1D via sin, then back-to-back LSB-first.
        load_a5(); start = 1'b1; shift_dir = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_sout1", sout, a5[7-i]);
            sin = v1d[7-i];
            step();
        end
        chk("b2b_q1", q, 8'h1D);
        chk("b2b_done1", done, 1'b1);
        start = 1'b1; shift_dir = 1'b1; sin = 1'b0;
        step();
        start = 1'b0;
        chk("b2b_busy_again", busy, 1'b1);
        chk("b2b_q_unchanged", q, 8'h1D);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_sout2", sout, v1d[i]);
            chk("b2b_busy2", busy, 1'b1);
            step();
        end
        chk("b2b_q2", q, 8'h00);
        chk("b2b_done2", done, 1'b1);
        chk("b2b_end_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_register_ctrl.md
Name: shift_register_ctrl

Overview:
- Parametrised WIDTH-bit register bank, the multi-bit successor of the single-bit D flip-flop.
- Adds clock enable, parallel load, shift/rotate modes, clear, and an automatic serial-transfer engine that shifts out all WIDTH bits with busy/done status.
- Serves as the general storage and serialiser primitive for the datapath and serial-link blocks.
- All state updates on rising edge of clk.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VALUE, 0, value q takes on reset and on the clear command (WIDTH bits).

Ports:
- clk  input  1  clock; rising edge active.
- reset  input  1  reset, synchronous, active-high; overrides all other inputs.
- en  input  1  clock enable; when 0, no state changes except reset.
- mode  input  3  operation select while idle (see Behaviour).
- pdata_in  input  WIDTH  parallel load data.
- sin  input  1  serial input, shifted into the vacated end.
- start  input  1  begin serial transfer of WIDTH bits (sampled when idle and en=1).
- shift_dir  input  1  transfer direction on start: 0 = MSB first (left), 1 = LSB first (right).
- q  output  WIDTH  register contents.
- sout  output  1  serial output; q[WIDTH-1] when dir_r=0, q[0] when dir_r=1 (combinational from q, dir_r).
- busy  output  1  high while serial transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset (reset=1 at rising edge, regardless of en): q=RESET_VALUE, dir_r=0, cnt=0, state=IDLE, busy=0, done=0. Reset mid-transfer aborts it; no done pulse.
- en=0: q, dir_r, cnt and state all hold. done is forced to 0 at that edge.
- done defaults to 0 every edge; it is 1 only on the edge that completes a transfer.
- States: IDLE, SHIFT. busy = (state==SHIFT).
- IDLE, en=1, start=1: state->SHIFT, cnt=WIDTH, dir_r=shift_dir, q unchanged. start has priority over mode.
- IDLE, en=1, start=0: mode is applied:
  - 000 hold.
  - 001 load: q=pdata_in.
  - 010 shift left: q={q[WIDTH-2:0],sin}; dir_r=0.
  - 011 shift right: q={sin,q[WIDTH-1:1]}; dir_r=1.
  - 100 rotate left: q={q[WIDTH-2:0],q[WIDTH-1]}; dir_r=0.
  - 101 rotate right: q={q[0],q[WIDTH-1:1]}; dir_r=1.
  - 110 clear: q=RESET_VALUE.
  - 111 reserved: hold.
- SHIFT, en=1: shift one bit in direction dir_r, taking sin into the vacated end; cnt=cnt-1.
  - When cnt goes 1->0: state->IDLE, done=1.
  - mode and start are ignored throughout SHIFT.
- Transfer timing: start sampled at edge k. Shifts occur at edges k+1..k+WIDTH (plus any en=0 stall cycles). After the final shift edge, busy=0 and done=1 for exactly one cycle.
- A new start may be sampled in the cycle done is high, giving back-to-back transfers.
- sout before each shift edge presents the bit about to leave, so the receiver samples sout on the same edge the shift occurs.
- cnt width is $clog2(WIDTH+1); it never wraps below 0.

Decomposition:
- Shared package holds:
  - mode encodings MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_CLR.
  - state typedef {IDLE, SHIFT}.
  - direction constants DIR_LEFT=0, DIR_RIGHT=1.
- One natural sub-module, shift_unit: combinational next-value logic. Inputs are q, sin, operation and direction; output is next q. Used by both the mode path and the transfer path.
- The FSM, counter and registers live in the top module.

Test Plan (WIDTH=8, RESET_VALUE=0):
- Parallel load and hold: mode=001, pdata_in=0xA5, en=1 for one edge, then mode=000 -> q=0xA5 and stays 0xA5; en=0 with mode=110 -> q remains 0xA5.
- Shift and rotate modes, each starting from q=0xA5:
  - Shift left, sin=1 -> 0x4B.
  - Shift right, sin=0 -> 0x52.
  - Rotate left -> 0x4B.
  - Rotate right -> 0xD2.
  - Clear -> 0x00.
- Serial transfer: q=0xA5, start=1, shift_dir=0, sin=0.
  - sout sampled at edges k+1..k+8 = 1,0,1,0,0,1,0,1.
  - q=0x00 after edge k+8.
  - busy high k+1..k+8; done=1 only in the cycle after edge k+8.
- Stall and ignore: during a transfer, hold en=0 for 3 cycles and pulse start=1 with mode=001 -> done is delayed 3 cycles, bit order is unchanged, and the extra start/load has no effect.
- Reset mid-transfer: assert reset after 4 shifts -> next edge gives q=0x00, busy=0, done=0; no done pulse follows.
- Back-to-back transfers: assert start in the done cycle with shift_dir=1 -> busy re-asserts immediately and the LSB-first sequence follows, with no idle gap.
